// File: rtl/dma_pkg.sv
// Shared types for the 8237A-style DMA arbitration/timing controller:
// transfer states, mode field encodings, channel index type, helpers.
package dma_pkg;

    typedef logic [1:0] ch_t;

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_S4 = 3'd5
    } state_t;

    // mode_reg[7:6]
    localparam logic [1:0] MD_DEMAND  = 2'b00;
    localparam logic [1:0] MD_SINGLE  = 2'b01;
    localparam logic [1:0] MD_BLOCK   = 2'b10;
    localparam logic [1:0] MD_CASCADE = 2'b11;

    // mode_reg[3:2]
    localparam logic [1:0] XF_VERIFY = 2'b00;
    localparam logic [1:0] XF_WRITE  = 2'b01;
    localparam logic [1:0] XF_READ   = 2'b10;

    function automatic logic [3:0] ch_onehot(input ch_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// Combinational 4-channel priority picker, fixed (ch0 first) or rotating
// from ptr. Ports: valid, ptr, rotate in; grant (one-hot), ch, any out.
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [3:0] valid,
    input  ch_t        ptr,
    input  logic       rotate,
    output logic [3:0] grant,
    output ch_t        ch,
    output logic       any
);

    ch_t start;
    ch_t idx;

    always_comb begin
        start = rotate ? ptr : 2'd0;
        ch    = 2'd0;
        idx   = 2'd0;
        any   = |valid;
        // Walk from farthest to nearest so the nearest valid wins last.
        for (int k = 3; k >= 0; k--) begin
            idx = start + ch_t'(k);
            if (valid[idx]) begin
                ch = idx;
            end
        end
        grant = any ? ch_onehot(ch) : 4'b0000;
    end

endmodule

// File: rtl/dma_priority_timing_ctrl.sv
// DMA arbitration + S0..S4 timing controller. Inputs: CLK, RESET_N, DREQ,
// HLDA, EOP_N_IN, mask_reg, req_reg, command_reg, mode_reg, tc. Outputs:
// HRQ, DACK, AEN, ADSTB, bus strobes, EOP_N_OUT, active_ch, load pulses,
// clr_req. Define DMA_EXT_WRITE_EN to start the write strobe in S2.
module dma_priority_timing_ctrl
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MODE_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [NUM_CH-1:0]        DREQ,
    input  logic                     HLDA,
    input  logic                     EOP_N_IN,
    input  logic [NUM_CH-1:0]        mask_reg,
    input  logic [NUM_CH-1:0]        req_reg,
    input  logic [7:0]               command_reg,
    input  logic [NUM_CH*MODE_W-1:0] mode_reg,
    input  logic [NUM_CH-1:0]        tc,
    output logic                     HRQ,
    output logic [NUM_CH-1:0]        DACK,
    output logic                     AEN,
    output logic                     ADSTB,
    output logic                     MEMR_N,
    output logic                     MEMW_N,
    output logic                     IOR_N,
    output logic                     IOW_N,
    output logic                     EOP_N_OUT,
    output ch_t                      active_ch,
    output logic                     ld_curr_temp,
    output logic                     ld_temp_curr,
    output logic [NUM_CH-1:0]        clr_req
);

    state_t            state;
    ch_t               ptr;
    logic              term_q;
    logic [3:0]        valid;
    logic [3:0]        grant;
    ch_t               win_ch;
    logic              any;
    logic [MODE_W-1:0] mode_act;
    logic [1:0]        md;
    logic [1:0]        xf;
    logic              term_now;
    logic              leave;
    logic              is_rd;
    logic              is_wr;
    logic              rd_ph;
    logic              wr_ph;
    logic              dack_on;
    logic [3:0]        oh;
    logic              unused_bits;

    assign valid = command_reg[2] ? 4'b0000 :
                   (((DREQ ^ {4{command_reg[6]}}) & ~mask_reg) | req_reg);

    dma_priority_encoder u_enc (
        .valid  (valid),
        .ptr    (ptr),
        .rotate (command_reg[4]),
        .grant  (grant),
        .ch     (win_ch),
        .any    (any)
    );

    assign mode_act = mode_reg[active_ch*MODE_W +: MODE_W];
    assign md       = mode_act[7:6];
    assign xf       = mode_act[3:2];
    assign oh       = ch_onehot(active_ch);
    assign term_now = tc[active_ch] | ~EOP_N_IN;

    // Termination, end of hold, or a mode that only moves one word
    // ends service; demand re-checks its own request (mask included).
    assign leave = term_q | ~HLDA
                 | (md == MD_SINGLE) | (md == MD_CASCADE)
                 | ((md == MD_DEMAND) & ~valid[active_ch]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_SI;
            active_ch <= 2'd0;
            ptr       <= 2'd0;
            term_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_SI: begin
                    if (any) begin
                        state     <= ST_S0;
                        active_ch <= win_ch;
                    end
                end
                ST_S0: begin
                    if (!any) begin
                        state <= ST_SI;
                    end else begin
                        active_ch <= win_ch;
                        if (HLDA) state <= ST_S1;
                    end
                end
                ST_S1: begin
                    term_q <= 1'b0;
                    state  <= ST_S2;
                end
                ST_S2: begin
                    term_q <= term_q | term_now;
                    state  <= ST_S3;
                end
                ST_S3: begin
                    term_q <= term_q | term_now;
                    state  <= ST_S4;
                end
                ST_S4: begin
                    if (leave) begin
                        state <= ST_SI;
                        ptr   <= active_ch + 2'd1;
                    end else begin
                        state <= ST_S1;
                    end
                end
                default: state <= ST_SI;
            endcase
        end
    end

    assign is_rd = (xf == XF_READ)  & (md != MD_CASCADE);
    assign is_wr = (xf == XF_WRITE) & (md != MD_CASCADE);
    assign rd_ph = (state == ST_S2) | (state == ST_S3);
`ifdef DMA_EXT_WRITE_EN
    assign wr_ph = (state == ST_S2) | (state == ST_S3);
`else
    assign wr_ph = (state == ST_S3);
`endif
    assign dack_on = rd_ph | (state == ST_S4);

    assign HRQ          = (state != ST_SI);
    assign AEN          = (state != ST_SI) & (state != ST_S0);
    assign ADSTB        = (state == ST_S1);
    assign ld_curr_temp = (state == ST_S1);
    assign ld_temp_curr = (state == ST_S4);
    assign DACK         = dack_on ?
                          (command_reg[7] ? oh : ~oh) :
                          {4{~command_reg[7]}};
    assign MEMR_N       = ~(rd_ph & is_rd);
    assign IOW_N        = ~(wr_ph & is_rd);
    assign IOR_N        = ~(rd_ph & is_wr);
    assign MEMW_N       = ~(wr_ph & is_wr);
    assign EOP_N_OUT    = ~((state == ST_S4) & term_q);
    assign clr_req      = ((state == ST_S4) & term_q) ? oh : 4'b0000;

    assign unused_bits = ^{grant, mode_act[5:4], mode_act[1:0],
                           command_reg[5], command_reg[3],
                           command_reg[1:0]};

endmodule

// File: tb/tb_dma_priority_timing_ctrl.sv
// Directed-vector bench for dma_priority_timing_ctrl with hand-computed
// expectations; honours DMA_EXT_WRITE_EN for the S2 write-strobe level.
module tb_dma_priority_timing_ctrl;
    import dma_pkg::*;

    logic        CLK;
    logic        RESET_N;
    logic [3:0]  DREQ;
    logic        HLDA;
    logic        EOP_N_IN;
    logic [3:0]  mask_reg;
    logic [3:0]  req_reg;
    logic [7:0]  command_reg;
    logic [31:0] mode_reg;
    logic [3:0]  tc;
    logic        HRQ;
    logic [3:0]  DACK;
    logic        AEN;
    logic        ADSTB;
    logic        MEMR_N;
    logic        MEMW_N;
    logic        IOR_N;
    logic        IOW_N;
    logic        EOP_N_OUT;
    ch_t         active_ch;
    logic        ld_curr_temp;
    logic        ld_temp_curr;
    logic [3:0]  clr_req;

    int n_vec = 0;
    int n_err = 0;

`ifdef DMA_EXT_WRITE_EN
    localparam logic WS2 = 1'b0;
`else
    localparam logic WS2 = 1'b1;
`endif

    dma_priority_timing_ctrl dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .HLDA         (HLDA),
        .EOP_N_IN     (EOP_N_IN),
        .mask_reg     (mask_reg),
        .req_reg      (req_reg),
        .command_reg  (command_reg),
        .mode_reg     (mode_reg),
        .tc           (tc),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .AEN          (AEN),
        .ADSTB        (ADSTB),
        .MEMR_N       (MEMR_N),
        .MEMW_N       (MEMW_N),
        .IOR_N        (IOR_N),
        .IOW_N        (IOW_N),
        .EOP_N_OUT    (EOP_N_OUT),
        .active_ch    (active_ch),
        .ld_curr_temp (ld_curr_temp),
        .ld_temp_curr (ld_temp_curr),
        .clr_req      (clr_req)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    int n_s1;
    int n_ld;
    int n_eop;
    int n_aen;
    logic last_ld;

    initial begin
        RESET_N     = 1'b0;
        DREQ        = 4'b0000;
        HLDA        = 1'b0;
        EOP_N_IN    = 1'b1;
        mask_reg    = 4'b0000;
        req_reg     = 4'b0000;
        command_reg = 8'h00;
        mode_reg    = {4{8'h48}};
        tc          = 4'b0000;

        #12;
        check("rst_hrq", HRQ, 0);
        check("rst_dack", DACK, 4'hF);
        check("rst_strb", {MEMR_N, MEMW_N, IOR_N, IOW_N}, 4'hF);
        check("rst_eop", EOP_N_OUT, 1);
        check("rst_ch", active_ch, 0);
        RESET_N = 1'b1;
        tick;
        check("idle_hrq", HRQ, 0);

        // 1: single read ch2, tc in S3
        DREQ = 4'b0100;
        tick;
        check("t1_hrq", HRQ, 1);
        check("t1_ch", active_ch, 2);
        check("t1_s0_aen", AEN, 0);
        HLDA = 1'b1;
        tick;
        check("t1_s1", {AEN, ADSTB, ld_curr_temp}, 3'b111);
        check("t1_s1_dack", DACK, 4'hF);
        check("t1_s1_memr", MEMR_N, 1);
        tick;
        check("t1_s2_dack", DACK, 4'b1011);
        check("t1_s2_memr", MEMR_N, 0);
        check("t1_s2_iow", IOW_N, WS2);
        check("t1_s2_adstb", ADSTB, 0);
        tc = 4'b0100;
        DREQ = 4'b0000;
        tick;
        check("t1_s3_strb", {MEMR_N, IOW_N}, 2'b00);
        tick;
        check("t1_s4_strb", {MEMR_N, IOW_N}, 2'b11);
        check("t1_s4_ld", ld_temp_curr, 1);
        check("t1_s4_eop", EOP_N_OUT, 0);
        check("t1_s4_clr", clr_req, 4'b0100);
        tc = 4'b0000;
        tick;
        check("t1_si", {HRQ, AEN, EOP_N_OUT}, 3'b001);
        check("t1_si_dack", DACK, 4'hF);
        check("t1_si_clr", clr_req, 0);

        // 2: fixed then rotating arbitration
        mode_reg = {4{8'h48}};
        DREQ = 4'b1010;
        tick;
        check("t2_fix_ch", active_ch, 1);
        repeat (4) tick;
        check("t2_fix_s4", ld_temp_curr, 1);
        check("t2_fix_eop", EOP_N_OUT, 1);
        tick;
        check("t2_fix_si", HRQ, 0);
        command_reg = 8'h10;
        tick;
        check("t2_rot_a", active_ch, 3);
        repeat (5) tick;
        tick;
        check("t2_rot_b", active_ch, 1);
        repeat (5) tick;
        tick;
        check("t2_rot_c", active_ch, 3);
        DREQ = 4'b0000;
        tick;
        check("t2_s0_drop", HRQ, 0);
        command_reg = 8'h00;

        // 3: block ch0, tc on 3rd transfer
        mode_reg[7:0] = 8'h88;
        DREQ = 4'b0001;
        tick;
        check("t3_ch", active_ch, 0);
        n_s1 = 0; n_ld = 0; n_eop = 0; n_aen = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (!HRQ) break;
            DREQ = 4'b0000;
            if (ld_curr_temp) n_s1++;
            if (ld_temp_curr) n_ld++;
            if (!EOP_N_OUT) n_eop++;
            if (AEN) n_aen++;
            tc = (n_s1 == 3) ? 4'b0001 : 4'b0000;
        end
        tc = 4'b0000;
        check("t3_done", HRQ, 0);
        check("t3_loops", n_s1, 3);
        check("t3_ld", n_ld, 3);
        check("t3_eop", n_eop, 1);
        check("t3_clks", n_aen, 12);
        mode_reg = {4{8'h48}};

        // 4: demand ch1, DREQ dropped in 2nd transfer
        mode_reg[15:8] = 8'h08;
        DREQ = 4'b0010;
        tick;
        check("t4_ch", active_ch, 1);
        n_s1 = 0; n_ld = 0; last_ld = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (!HRQ) break;
            if (ld_curr_temp) n_s1++;
            if (n_s1 == 2) DREQ = 4'b0000;
            if (ld_temp_curr) n_ld++;
            last_ld = ld_temp_curr;
        end
        check("t4_done", HRQ, 0);
        check("t4_xfers", n_ld, 2);
        check("t4_last_s4", last_ld, 1);
        mode_reg = {4{8'h48}};

        // 5: masking, software request, controller disable
        command_reg = 8'h80;
        mask_reg = 4'hF;
        DREQ = 4'hF;
        repeat (3) tick;
        check("t5_mask_hrq", HRQ, 0);
        check("t5_idle_dack", DACK, 4'h0);
        req_reg = 4'b1000;
        tick;
        check("t5_req_hrq", HRQ, 1);
        check("t5_req_ch", active_ch, 3);
        tick;
        req_reg = 4'b0000;
        tick;
        check("t5_s2_dack", DACK, 4'b1000);
        repeat (3) tick;
        check("t5_si", HRQ, 0);
        command_reg = 8'h04;
        mask_reg = 4'h0;
        req_reg = 4'hF;
        repeat (3) tick;
        check("t5_dis_hrq", HRQ, 0);
        command_reg = 8'h00;
        req_reg = 4'h0;
        DREQ = 4'h0;
        tick;

        // 6: single write ch0, reset in S2
        mode_reg[7:0] = 8'h44;
        DREQ = 4'b0001;
        repeat (3) tick;
        check("t6_s2_ior", IOR_N, 0);
        check("t6_s2_memw", MEMW_N, WS2);
        check("t6_s2_memr", MEMR_N, 1);
        RESET_N = 1'b0;
        #1;
        check("t6_rst_hrq", {HRQ, AEN, ADSTB}, 3'b000);
        check("t6_rst_dack", DACK, 4'hF);
        check("t6_rst_strb", {MEMR_N, MEMW_N, IOR_N, IOW_N}, 4'hF);
        check("t6_rst_ch", active_ch, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick;
        check("t6_rel_hrq", HRQ, 1);
        DREQ = 4'b0000;
        tick;
        check("t6_rel_drop", HRQ, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
